// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the sequential divider.
//   div_state_t   : FSM states of div_seq_param
//   DEFAULT_WIDTH : default operand/result width
//   abs_w         : two's-complement magnitude of a w-bit value carried in a
//                   MAX_W-bit container (bits above w are ignored and returned 0)
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_W         = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // The most negative value maps onto itself (its magnitude wraps), which is
  // exactly what the unsigned core needs for the -2^(w-1) / -1 case.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                             input int unsigned       w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] sbit;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    sbit = v >> (w - 1);
    if (sbit[0]) abs_w = (~v + MAX_W'(1)) & mask;
    else         abs_w = v & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   i_a : partial remainder (always < i_d on entry)
//   i_q : dividend/quotient shift register
//   i_d : divisor magnitude
//   o_a : next partial remainder
//   o_q : next quotient register (new quotient bit in LSB)
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_q
);

  // Shifted remainder needs one extra bit; since i_a < i_d it stays below
  // 2*i_d, so the result always fits back into WIDTH bits.
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_dx;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_sh   = {i_a, i_q[WIDTH-1]};
  assign w_dx   = {1'b0, i_d};
  assign w_ge   = (w_sh >= w_dx);
  assign w_diff = w_sh - w_dx;

  assign o_a = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq_param.sv
// div_seq_param: sequential restoring divider, one quotient bit per clock.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   start     : request, accepted in IDLE or DONE
//   sgn       : 1 = signed divide, 0 = unsigned (sampled with start)
//   dividend  : sampled with start
//   divisor   : sampled with start
//   busy      : high while iterating or fixing signs
//   done      : one-cycle pulse, results valid
//   quotient  : registered result, held until the next accepted request
//   remainder : registered result, held until the next accepted request
//   div_zero  : registered, set when the divisor was zero
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_abs_n;
  logic [WIDTH-1:0] w_abs_d;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    apply_sign = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_abs_n = WIDTH'(abs_w(MAX_W'(dividend), WIDTH));
  assign w_abs_d = WIDTH'(abs_w(MAX_W'(divisor), WIDTH));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_d (r_d),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  // Working registers (r_a, r_q, r_d, sign flags) are fully reloaded on every
  // accepted request, so only control and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_neg_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r <= sgn & dividend[WIDTH-1];
            r_a     <= '0;
            r_q     <= sgn ? w_abs_n : dividend;
            r_d     <= sgn ? w_abs_d : divisor;
            r_cnt   <= CNT_W'(WIDTH);
            if (divisor == '0) begin
              // Zero divisor skips iteration entirely; remainder is the raw operand.
              r_state   <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              r_state  <= CALC;
              busy     <= 1'b1;
              div_zero <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= FIX;
        end
        FIX: begin
          // Truncating division: quotient sign is the XOR of operand signs,
          // remainder follows the dividend.
          quotient  <= apply_sign(r_q, r_neg_q);
          remainder <= apply_sign(r_a, r_neg_r);
          busy      <= 1'b0;
          done      <= 1'b1;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, sgn = 1'b0;
  logic [W-1:0]  dividend = '0, divisor = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  quotient, remainder;

  logic          start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]    dividend8 = '0, divisor8 = '0;
  logic          busy8, done8, dz8;
  logic [7:0]    q8, r8;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero)
  );

  div_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8),
    .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(q8),
    .remainder(r8), .div_zero(dz8)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
    bit           has_lit;
    logic [W-1:0] lq;
    logic [W-1:0] lr;
  } exp_t;

  exp_t         expq[$];
  int           cyc = 0;
  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sa, sb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (!s) begin
        q = a / b; r = a % b;
      end else begin
        sa = $signed(a); sb = $signed(b);
        if (sa == -32768 && sb == -1) begin
          q = 16'h8000; r = '0;
        end else begin
          q = 16'(sa / sb); r = 16'(sa % sb);
        end
      end
    end
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input bit has_lit, input logic [W-1:0] lq, input logic [W-1:0] lr);
    exp_t e;
    model(a, b, s, e.q, e.r, e.dz);
    e.due     = cyc + ((b == 0) ? 0 : W + 1);
    e.has_lit = has_lit;
    e.lq      = lq;
    e.lr      = lr;
    expq.push_back(e);
  endtask

  // Compare process: busy/done timing and held outputs every cycle, results on done.
  initial begin
    bit ed, eb;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        ed = 1'b0; eb = 1'b0;
        if (expq.size() > 0) begin
          ed = (cyc == expq[0].due);
          eb = !expq[0].dz && (cyc < expq[0].due);
        end
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(eb));
        if (ed) begin
          chk("quotient", 32'(quotient), 32'(expq[0].q));
          chk("remainder", 32'(remainder), 32'(expq[0].r));
          chk("div_zero", 32'(div_zero), 32'(expq[0].dz));
          if (expq[0].has_lit) begin
            chk("lit_quotient", 32'(quotient), 32'(expq[0].lq));
            chk("lit_remainder", 32'(remainder), 32'(expq[0].lr));
          end
          hold_q = expq[0].q;
          hold_r = expq[0].r;
          void'(expq.pop_front());
        end
        chk("hold_quotient", 32'(quotient), 32'(hold_q));
        chk("hold_remainder", 32'(remainder), 32'(hold_r));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit has_lit, input logic [W-1:0] lq, input logic [W-1:0] lr);
    @(negedge clk);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    push(a, b, s, has_lit, lq, lr);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (expq.size() > 0 && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] lq, input logic [7:0] lr);
    int e;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; dividend8 = a; divisor8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    e = cyc;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    if (!seen) chk("w8_done_timeout", 32'd0, 32'd1);
    else begin
      chk("w8_latency", 32'(cyc - e), 32'd9);
      chk("w8_quotient", 32'(q8), 32'(lq));
      chk("w8_remainder", 32'(r8), 32'(lr));
      chk("w8_div_zero", 32'(dz8), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_w8_busy", 32'(busy8), 32'd0);
    chk("rst_w8_done", 32'(done8), 32'd0);
    chk("rst_w8_q", 32'(q8), 32'd0);
    chk("rst_w8_r", 32'(r8), 32'd0);
    chk("rst_w8_dz", 32'(dz8), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unsigned, signed, extremes, zero divisor
    issue(16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2);        drain();
    issue(16'hFF9C, 16'd7, 1'b1, 1'b1, 16'hFFF2, 16'hFFFE);  drain();
    issue(16'd100, 16'hFFF9, 1'b1, 1'b1, 16'hFFF2, 16'h0002); drain();
    issue(16'hFFFF, 16'd1, 1'b0, 1'b1, 16'hFFFF, 16'h0000);  drain();
    issue(16'h8000, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 16'h0000); drain();
    issue(16'd5, 16'd9, 1'b0, 1'b1, 16'd0, 16'd5);           drain();
    issue(16'd1234, 16'd0, 1'b0, 1'b1, 16'hFFFF, 16'd1234);  drain();
    issue(16'hFFFB, 16'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFB);  drain();
    issue(16'd60000, 16'd250, 1'b0, 1'b1, 16'd240, 16'd0);   drain();
    issue(16'hFC18, 16'hFFCE, 1'b1, 1'b1, 16'd20, 16'd0);    drain();
    issue(16'hFC17, 16'hFFCE, 1'b1, 1'b1, 16'd20, 16'hFFFF); drain();

    // start pulsed during CALC must be ignored
    issue(16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2);
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high: back-to-back results every W+2 cycles
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk); #1;
    push(16'd1000, 16'd3, 1'b0, 1'b1, 16'd333, 16'd1);
    sgn = 1'b1; dividend = 16'hFF9C; divisor = 16'd7;
    repeat (W + 2) @(posedge clk);
    #1;
    push(16'hFF9C, 16'd7, 1'b1, 1'b1, 16'hFFF2, 16'hFFFE);
    sgn = 1'b0; dividend = 16'd65535; divisor = 16'd256;
    repeat (W + 2) @(posedge clk);
    #1;
    push(16'd65535, 16'd256, 1'b0, 1'b1, 16'd255, 16'd255);
    start = 1'b0;
    drain();

    // Reset in the middle of CALC
    issue(16'd100, 16'd7, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expq.delete();
    hold_q = '0;
    hold_r = '0;
    @(negedge clk);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    rst = 1'b1;
    issue(16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2);        drain();

    // WIDTH=8 instance
    run8(8'd200, 8'd3, 1'b0, 8'd66, 8'd2);
    run8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
